// File: rtl/frame_update_sequencer_if.sv
// frame_update_sequencer_if: frame handshake, proposal and committed-position bundle.
interface frame_update_sequencer_if;
    logic       frame_tick;
    logic       step;
    logic       done1;
    logic       done2;
    logic [9:0] prop_x1;
    logic [9:0] prop_y1;
    logic [9:0] prop_x2;
    logic [9:0] prop_y2;
    logic [9:0] x1;
    logic [9:0] y1;
    logic [9:0] x2;
    logic [9:0] y2;
    logic       hit;
    logic       busy;
    logic       overrun;
    modport master (
        input  frame_tick, done1, done2, prop_x1, prop_y1, prop_x2, prop_y2,
        output step, x1, y1, x2, y2, hit, busy, overrun
    );
    modport slave (
        output frame_tick, done1, done2, prop_x1, prop_y1, prop_x2, prop_y2,
        input  step, x1, y1, x2, y2, hit, busy, overrun
    );
endinterface

// File: rtl/frame_update_sequencer.sv
// frame_update_sequencer: per-frame step/collect/collide/resolve/commit controller for two sprites.
module frame_update_sequencer #(
    parameter int W1      = 46,
    parameter int H1      = 60,
    parameter int W2      = 60,
    parameter int H2      = 80,
    parameter int INIT_X1 = 50,
    parameter int INIT_Y1 = 290,
    parameter int INIT_X2 = 375,
    parameter int INIT_Y2 = 300,
    parameter int TIMEOUT = 1023
) (
    input logic clk,
    input logic rst,
    frame_update_sequencer_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [10:0] DW1 = 11'(W1);
    localparam logic [10:0] DH1 = 11'(H1);
    localparam logic [10:0] DW2 = 11'(W2);
    localparam logic [10:0] DH2 = 11'(H2);

    typedef enum logic [2:0] {IDLE, WAIT, CHECK, RES_X, RES_Y, COMMIT} state_t;

    state_t state, state_d;
    logic f1, f2, both, timeout, ov_p, ov_x, ov_y, h;
    logic [CW-1:0] cnt;
    logic [9:0] px1, py1, px2, py2, cx1, cy1;
    logic [9:0] cur_x1, cur_y1, cur_x2, cur_y2;

    // Operands widened by one bit so edge sums near 1023 compare without wrapping.
    function automatic logic overlap(
        input logic [9:0] ax, input logic [9:0] ay, input logic [10:0] wa, input logic [10:0] ha,
        input logic [9:0] bx, input logic [9:0] by, input logic [10:0] wb, input logic [10:0] hb
    );
        return ({1'b0, ax} < {1'b0, bx} + wb) && ({1'b0, ax} + wa > {1'b0, bx}) &&
               ({1'b0, ay} < {1'b0, by} + hb) && ({1'b0, ay} + ha > {1'b0, by});
    endfunction

    assign both = (f1 | bus.done1) & (f2 | bus.done2);
    assign ov_p = overlap(px1, py1, DW1, DH1, px2, py2, DW2, DH2);
    assign ov_x = overlap(px1, cur_y1, DW1, DH1, px2, py2, DW2, DH2);
    assign ov_y = overlap(cur_x1, py1, DW1, DH1, px2, py2, DW2, DH2);

    always_comb begin
        state_d = state;
        timeout = 1'b0;
        case (state)
            IDLE:    state_d = bus.frame_tick ? WAIT : IDLE;
            WAIT: begin
                timeout = !both && cnt == CW'(TIMEOUT - 1);
                state_d = both ? CHECK : timeout ? IDLE : WAIT;
            end
            CHECK:   state_d = ov_p ? RES_X : COMMIT;
            RES_X:   state_d = ov_x ? RES_Y : COMMIT;
            RES_Y:   state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            f1          <= 1'b0;
            f2          <= 1'b0;
            cnt         <= '0;
            px1         <= '0;
            py1         <= '0;
            px2         <= '0;
            py2         <= '0;
            cx1         <= '0;
            cy1         <= '0;
            h           <= 1'b0;
            cur_x1      <= 10'(INIT_X1);
            cur_y1      <= 10'(INIT_Y1);
            cur_x2      <= 10'(INIT_X2);
            cur_y2      <= 10'(INIT_Y2);
            bus.hit     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.step    <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            state       <= state_d;
            bus.step    <= state == IDLE && bus.frame_tick;
            bus.busy    <= state_d != IDLE;
            bus.overrun <= timeout || (bus.frame_tick && state != IDLE);
            if (state == IDLE) begin
                f1  <= 1'b0;
                f2  <= 1'b0;
                cnt <= '0;
            end
            if (state == WAIT) begin
                f1  <= f1 | bus.done1;
                f2  <= f2 | bus.done2;
                cnt <= cnt + 1'b1;
            end
            if (state == WAIT && both) begin
                px1 <= bus.prop_x1;
                py1 <= bus.prop_y1;
                px2 <= bus.prop_x2;
                py2 <= bus.prop_y2;
            end
            if (state == CHECK) begin
                h   <= ov_p;
                cx1 <= px1;
                cy1 <= py1;
            end
            if (state == RES_X)
                cy1 <= cur_y1;
            // Fall back to the old x always; keep old y too if the y-only move still collides.
            if (state == RES_Y) begin
                cx1 <= cur_x1;
                cy1 <= ov_y ? cur_y1 : py1;
            end
            if (state == COMMIT) begin
                cur_x1  <= cx1;
                cur_y1  <= cy1;
                cur_x2  <= px2;
                cur_y2  <= py2;
                bus.hit <= h;
            end
        end
    end

    assign bus.x1 = cur_x1;
    assign bus.y1 = cur_y1;
    assign bus.x2 = cur_x2;
    assign bus.y2 = cur_y2;
endmodule

// File: tb/tb_frame_update_sequencer.sv
// tb_frame_update_sequencer: directed and randomized frames checked against a rule-level sprite model.
module tb_frame_update_sequencer;
    localparam int W1 = 46, H1 = 60, W2 = 60, H2 = 80;
    localparam int IX1 = 50, IY1 = 290, IX2 = 375, IY2 = 300;
    localparam int TMO = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_update_sequencer_if bus();
    frame_update_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    int nvec = 0;
    int nerr = 0;
    int mx1 = IX1, my1 = IY1, mx2 = IX2, my2 = IY2, mhit = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pos(input string tag);
        chk({tag, ".x1"}, 32'(bus.x1), 32'(mx1));
        chk({tag, ".y1"}, 32'(bus.y1), 32'(my1));
        chk({tag, ".x2"}, 32'(bus.x2), 32'(mx2));
        chk({tag, ".y2"}, 32'(bus.y2), 32'(my2));
        chk({tag, ".hit"}, 32'(bus.hit), 32'(mhit));
    endtask

    function automatic bit ov(int ax, int ay, int wa, int ha, int bx, int by, int wb, int hb);
        return ax < bx + wb && ax + wa > bx && ay < by + hb && ay + ha > by;
    endfunction

    task automatic model_reset();
        mx1 = IX1; my1 = IY1; mx2 = IX2; my2 = IY2; mhit = 0;
    endtask

    // Player 2 always gets its proposal; player 1 tries full move, x-only, y-only, then stays.
    task automatic resolve(input int a1, input int b1, input int a2, input int b2,
                           output int nx, output int ny, output int nh, output int lat);
        nh = 1;
        lat = 4;
        if (!ov(a1, b1, W1, H1, a2, b2, W2, H2)) begin
            nx = a1; ny = b1; nh = 0; lat = 2;
        end else if (!ov(a1, my1, W1, H1, a2, b2, W2, H2)) begin
            nx = a1; ny = my1; lat = 3;
        end else if (!ov(mx1, b1, W1, H1, a2, b2, W2, H2)) begin
            nx = mx1; ny = b1;
        end else begin
            nx = mx1; ny = my1;
        end
    endtask

    task automatic start(input int a1, input int b1, input int a2, input int b2);
        bus.prop_x1 = 10'(a1); bus.prop_y1 = 10'(b1);
        bus.prop_x2 = 10'(a2); bus.prop_y2 = 10'(b2);
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        chk("step_pulse", 32'(bus.step), 1);
        chk("busy_start", 32'(bus.busy), 1);
        chk("ovr_start", 32'(bus.overrun), 0);
    endtask

    // Runs tick, done phase (done d cycles after tick, pulse or level) and, if fin, the commit.
    task automatic frame(input int a1, input int b1, input int a2, input int b2,
                         input int d1, input int d2, input bit lv1, input bit lv2,
                         input int xt, input bit fin);
        int last, nx, ny, nh, lat;
        last = d1 > d2 ? d1 : d2;
        start(a1, b1, a2, b2);
        for (int k = 1; k <= last; k++) begin
            bus.done1 = lv1 ? k >= d1 : k == d1;
            bus.done2 = lv2 ? k >= d2 : k == d2;
            bus.frame_tick = k == xt;
            cyc();
            chk("step_once", 32'(bus.step), 0);
            chk("busy_wait", 32'(bus.busy), 1);
            chk("ovr_wait", 32'(bus.overrun), 32'(k == xt));
            chk_pos("hold_wait");
        end
        bus.done1 = 1'b0;
        bus.done2 = 1'b0;
        bus.frame_tick = 1'b0;
        if (!fin) return;
        resolve(a1, b1, a2, b2, nx, ny, nh, lat);
        for (int j = 1; j <= lat; j++) begin
            cyc();
            if (j < lat) begin
                chk("busy_res", 32'(bus.busy), 1);
                chk_pos("hold_res");
            end else begin
                mx1 = nx; my1 = ny; mx2 = a2; my2 = b2; mhit = nh;
                chk_pos("commit");
                chk("busy_done", 32'(bus.busy), 0);
            end
        end
        cyc();
        chk("idle_step", 32'(bus.step), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        chk_pos("after_commit");
    endtask

    initial begin
        int a1, b1, a2, b2, d1, d2, last;
        bus.frame_tick = 1'b0;
        bus.done1 = 1'b0;
        bus.done2 = 1'b0;
        bus.prop_x1 = '0; bus.prop_y1 = '0; bus.prop_x2 = '0; bus.prop_y2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_pos("reset");
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_ovr", 32'(bus.overrun), 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("no_tick_step", 32'(bus.step), 0);
        end

        frame(60, 290, 370, 300, 3, 5, 0, 0, 0, 1);
        frame(320, 290, 375, 300, 1, 1, 0, 0, 0, 1);
        frame(340, 290, 375, 300, 2, 2, 1, 1, 0, 1);
        frame(380, 200, 375, 300, 1, 2, 0, 0, 0, 1);
        frame(384, 230, 375, 300, 2, 1, 0, 0, 0, 1);
        frame(380, 200, 375, 300, 1, 1, 0, 0, 0, 1);
        frame(384, 260, 375, 300, 1, 1, 0, 0, 0, 1);
        frame(100, 100, 500, 100, 2, 6, 0, 1, 3, 1);

        // Stray done1 while idle must not satisfy the next frame's handshake.
        bus.done1 = 1'b1;
        cyc();
        bus.done1 = 1'b0;
        cyc();
        frame(120, 110, 500, 100, 4, 2, 0, 0, 0, 1);

        start(200, 200, 600, 200);
        for (int k = 1; k <= TMO; k++) begin
            bus.done1 = k == 1;
            cyc();
            if (k <= 2 || k >= TMO - 2) begin
                chk("tmo_busy", 32'(bus.busy), 32'(k < TMO));
                chk("tmo_ovr", 32'(bus.overrun), 32'(k == TMO));
                chk_pos("tmo_hold");
            end
        end
        bus.done1 = 1'b0;
        cyc();
        chk("tmo_ovr_end", 32'(bus.overrun), 0);
        chk("tmo_busy_end", 32'(bus.busy), 0);
        chk_pos("tmo_after");

        frame(320, 290, 375, 300, 1, 1, 0, 0, 0, 1);
        frame(340, 290, 375, 300, 1, 2, 0, 0, 0, 0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_reset();
        chk_pos("mid_reset");
        chk("mid_reset_busy", 32'(bus.busy), 0);
        chk("mid_reset_step", 32'(bus.step), 0);
        frame(70, 280, 380, 310, 2, 3, 0, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            a2 = 300 + $urandom_range(0, 100);
            b2 = 250 + $urandom_range(0, 100);
            a1 = a2 - 80 + $urandom_range(0, 160);
            b1 = b2 - 100 + $urandom_range(0, 200);
            d1 = $urandom_range(1, 6);
            d2 = $urandom_range(1, 6);
            last = d1 > d2 ? d1 : d2;
            frame(a1, b1, a2, b2, d1, d2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0 ? $urandom_range(1, last) : 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
